// File: rtl/adc_sample_collector.sv
// rtl/adc_sample_collector.sv - round-robin ADC sample scanner with host-drained sample FIFO
module adc_sample_collector #(
  parameter int         NUM_CHANNELS = 2,
  parameter int         FIFO_DEPTH   = 64,
  parameter logic [7:0] BASE_ADDR    = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] data_in,
  input  logic        enable,
  input  logic        re,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
  output logic        data_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, REQ, CHECK} state_t;

  state_t        state;
  logic [CW-1:0] ch;
  logic [CW-1:0] next_ch;
  logic          run;
  logic [15:0]   last_seq [NUM_CHANNELS];
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   drops;
  logic          overflow;
  logic          data_rd_q;

  logic hit, reg_rd, data_rd, ctrl_wr, clear, ovf_clr;
  logic fifo_empty, fifo_full, pop, push_req, push, drop;
  logic unused_bits;

  assign hit        = enable && (addr[15:8] == BASE_ADDR);
  assign reg_rd     = hit && re;
  assign data_rd    = reg_rd && (addr[7:0] == 8'h10);
  assign ctrl_wr    = hit && wr && (addr[7:0] == 8'h01);
  assign clear      = ctrl_wr && data_in[1];
  assign ovf_clr    = hit && wr && (addr[7:0] == 8'h02) && data_in[2];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign next_ch    = (ch == LAST_CH) ? '0 : ch + 1'b1;
  assign data_ready = !fifo_empty;
  assign unused_bits = ^data_in[31:3];

  // Only the first cycle of a held DATA read pops; clear wins over any FIFO traffic.
  assign pop      = data_rd && !data_rd_q && !fifo_empty && !clear;
  assign push_req = (state == CHECK) && (sample_data != '0) && (sample_data[31:16] != last_seq[ch]);
  assign push     = push_req && (!fifo_full || pop) && !clear;
  assign drop     = push_req && fifo_full && !pop && !clear;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      ch             <= '0;
      output_sample  <= 1'b0;
      channel_select <= 8'd0;
    end else if (clear) begin
      state         <= IDLE;
      ch            <= '0;
      output_sample <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state          <= REQ;
            ch             <= '0;
            output_sample  <= 1'b1;
            channel_select <= 8'd0;
          end
        end
        REQ: begin
          state         <= CHECK;
          output_sample <= 1'b0;
        end
        CHECK: begin
          if (run) begin
            state          <= REQ;
            ch             <= next_ch;
            output_sample  <= 1'b1;
            channel_select <= 8'(next_ch);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          output_sample <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drops     <= 16'd0;
      overflow  <= 1'b0;
      data_rd_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) last_seq[i] <= 16'd0;
    end else begin
      data_rd_q <= data_rd;
      if (ctrl_wr) run <= data_in[0];
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drops    <= 16'd0;
        overflow <= 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) last_seq[i] <= 16'd0;
      end else begin
        // A rejected sample still counts as seen, so it is not retried next round.
        if (push_req) last_seq[ch] <= sample_data[31:16];
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (drop && (drops != 16'hFFFF)) drops <= drops + 1'b1;
        if (ovf_clr)   overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= sample_data[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= 16'd0;
    end else if (reg_rd) begin
      case (addr[7:0])
        8'h01:   data_out <= {15'd0, run};
        8'h02:   data_out <= {13'd0, overflow, fifo_full, fifo_empty};
        8'h03:   data_out <= 16'(count);
        8'h04:   data_out <= drops;
        8'h09:   data_out <= 16'h5C01;
        8'h10:   data_out <= fifo_empty ? 16'd0 : mem[rd_ptr];
        default: data_out <= 16'd0;
      endcase
    end else begin
      data_out <= 16'd0;
    end
  end

endmodule

// File: doc/adc_sample_collector.md
# adc_sample_collector

Downstream consumer of the ADC controller's `output_sample`/`channel_select`/`sample_data` port. It polls every ADC channel in round-robin order and pushes each new sample into an internal FIFO. New means non-zero `sample_data` whose sequence number differs from the last one captured for that channel. The host drains the FIFO over the EBI register bus, so no sample is lost between host polls.

## Interface
- `NUM_CHANNELS`, default 2: channels scanned, 0..NUM_CHANNELS-1 (max 8).
- `FIFO_DEPTH`, default 64: FIFO entries, power of two.
- `BASE_ADDR`, default 8'hF0: value of `addr[15:8]` that selects this block.
- `clk` input, 1: system clock.
- `reset` input, 1: synchronous, active-low reset (0 = reset).
- `addr` input, 16: EBI address. `[15:8]` is the block select, `[7:0]` is the register.
- `data_in` input, 32: EBI write data.
- `enable` input, 1: EBI chip select.
- `re` input, 1: EBI read strobe.
- `wr` input, 1: EBI write strobe.
- `data_out` output, 16: registered EBI read data.
- `output_sample` output, 1: sample request to the ADC controller.
- `channel_select` output, 8: channel being requested.
- `sample_data` input, 32: `{seq[15:0], sample[15:0]}`. Valid the cycle after the `output_sample` cycle. Zero means no recording is active.
- `data_ready` output, 1: FIFO not empty (host interrupt).

## Operation
- Block hit: `enable & (addr[15:8] == BASE_ADDR)`.
- Register map (`addr[7:0]`):
  - 0x01 CTRL. Write: bit0 = run, bit1 = clear (self-clearing pulse). Read: bit0 = run.
  - 0x02 STATUS. Read: bit0 = empty, bit1 = full, bit2 = overflow (sticky). Writing bit2 = 1 clears overflow.
  - 0x03 COUNT. Read: FIFO occupancy, zero-extended.
  - 0x04 DROPS. Read: count of dropped samples, 16-bit, saturates at 16'hFFFF.
  - 0x09 ID. Read: 16'h5C01.
  - 0x10 DATA. Read: FIFO head; the read pops the head.
- `data_out` rule: on a hit with `re` high, `data_out` is loaded with the selected register. Otherwise `data_out` is 0.
- Pop rule: a pop happens only on the first cycle of a DATA read, i.e. the rising edge of (hit & `re` & `addr[7:0] == 0x10`). Holding `re` does not pop again.
- Reading DATA while the FIFO is empty returns 0 and does not pop.
- Scanner FSM, states IDLE, REQ, CHECK:
  - IDLE: `output_sample` = 0. Go to REQ with ch = 0 when run = 1.
  - REQ: `output_sample` = 1, `channel_select` = ch. Always go to CHECK.
  - CHECK: `output_sample` = 0. Evaluate `sample_data`. Then:
    - if run = 1: ch advances, wrapping NUM_CHANNELS-1 → 0, and the FSM goes to REQ;
    - if run = 0: the FSM goes to IDLE.
  - `channel_select` holds its last value outside REQ.
- Capture rule in CHECK: a push is requested when `sample_data != 0` and `sample_data[31:16] != last_seq[ch]`.
  - On a push request, `last_seq[ch]` is updated whether or not the push is accepted.
  - The FIFO entry is `sample_data[15:0]`.
- FIFO full:
  - A push without a same-cycle pop is dropped. DROPS increments and overflow sets.
  - A push together with a pop is accepted; COUNT stays FIFO_DEPTH.
- Simultaneous push and pop when not full: both happen; COUNT is unchanged.
- Clear pulse: on the next clock, the following all reset:
  - FIFO pointers and COUNT → 0;
  - DROPS → 0 and overflow → 0;
  - `last_seq[*]` → 0;
  - FSM → IDLE and ch → 0.
  - run keeps the value written in the same write, so a write of 0x3 gives clear followed by run.
  - Clear has priority over any push or pop in that cycle.
- Reset (`reset` = 0 at a clock edge):
  - `data_out` = 0, `output_sample` = 0, `channel_select` = 0, `data_ready` = 0;
  - run = 0, FSM = IDLE, FIFO empty, DROPS = 0, overflow = 0, `last_seq[*]` = 0.
  - Reset mid-transfer abandons the request; no push happens.

## Timing
- Request cadence: with run held, `output_sample` is high every other cycle, giving one channel per 2 cycles and a full round of 2·NUM_CHANNELS cycles.
- Capture: `sample_data` is sampled in CHECK, one cycle after REQ. A push is visible in COUNT and `data_ready` one cycle after CHECK.
- Read latency: `data_out` is valid one clock after the read strobe is sampled. The pop takes effect on the same edge, and COUNT reflects it one cycle later.
- Run 1→0 written during REQ: the FSM still completes CHECK, including any push, and then returns to IDLE.
- Write to CTRL takes effect on the next clock edge.

## Test plan
- Reset, then read ID → `data_out` = 16'h5C01 one cycle after `re`. STATUS = 0x0001.
- run = 1, NUM_CHANNELS = 2, `sample_data` = 0x0001_2ABC for ch0 and 0 for ch1 → `channel_select` alternates 0,1. Exactly one push occurs, COUNT = 1, DATA read returns 0x2ABC, then COUNT = 0.
- Same `seq` repeated for 10 rounds, then `seq` +1 → exactly 2 entries total.
- Fill to FIFO_DEPTH, then 3 further new samples → full = 1, DROPS = 3, overflow = 1. Writing STATUS bit2 clears overflow; DROPS stays 3.
- Hold `re` on DATA for 4 cycles → exactly one pop.
- Full FIFO with a push and DATA pop in the same cycle → COUNT stays 64 and DROPS is unchanged.
- CTRL write 0x3 while busy → FIFO empty, DROPS = 0, the scan restarts at ch0 two cycles later.
- Assert `reset` = 0 during REQ → `output_sample` = 0 on the next cycle and no push occurs.
